// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: control-step sequencer for register-register ALU instructions.
// Walks the datapath through fetch (T0..T2), operand staging (T3..T4) and
// writeback (T5, plus T6 for the HI half of multiply/divide results).
// Optional feature macro: ALU_SEQ_PRELOAD_EN adds a two-step memory-to-register
// preload path (PRE_A/PRE_B) driven by pre_valid/pre_idx while idle.
// Every output is a register loaded with the decode of the state being entered,
// so nothing on the input ports reaches a strobe combinationally.
module alu_rr_sequencer #(
    parameter int              NUM_REGS = 16,
    parameter int              IDX_W    = 4,
    parameter int              OP_W     = 5,
    parameter logic [OP_W-1:0] MUL_OP   = OP_W'(5'b01111),
    parameter logic [OP_W-1:0] DIV_OP   = OP_W'(5'b10000)
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     opcode_in,
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    input  logic [IDX_W-1:0]    rc,
`ifdef ALU_SEQ_PRELOAD_EN
    input  logic                pre_valid,
    input  logic [IDX_W-1:0]    pre_idx,
`endif
    output logic                ready,
    output logic                done,
    output logic [3:0]          state,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                z_low_out,
    output logic                z_high_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [OP_W-1:0]     alu_op
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_PRE_A = 4'd8,
        S_PRE_B = 4'd9
    } state_e;

    state_e                state_q;
    logic                  ready_q;
    logic                  done_q;
    logic [NUM_REGS-1:0]   r_in_q;
    logic [NUM_REGS-1:0]   r_out_q;
    logic                  pc_out_q;
    logic                  mar_in_q;
    logic                  inc_pc_q;
    logic                  read_q;
    logic                  mdr_in_q;
    logic                  mdr_out_q;
    logic                  ir_in_q;
    logic                  y_in_q;
    logic                  z_in_q;
    logic                  z_low_out_q;
    logic                  z_high_out_q;
    logic                  hi_in_q;
    logic                  lo_in_q;
    logic [OP_W-1:0]       alu_op_q;

    // Instruction fields captured when a command is accepted.
    logic [OP_W-1:0]       op_q;
    logic [IDX_W-1:0]      ra_q;
    logic [IDX_W-1:0]      rb_q;
    logic [IDX_W-1:0]      rc_q;
`ifdef ALU_SEQ_PRELOAD_EN
    logic [IDX_W-1:0]      pre_idx_q;
`endif

    // One-hot register select; an index past the register file yields no strobe.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    // Multiply and divide produce a 64-bit result that needs the extra HI step.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == MUL_OP) || (op == DIV_OP);
    endfunction

    // Sequencer FSM: advances one step per clock and registers the strobes of the next step.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            r_in_q       <= '0;
            r_out_q      <= '0;
            pc_out_q     <= 1'b0;
            mar_in_q     <= 1'b0;
            inc_pc_q     <= 1'b0;
            read_q       <= 1'b0;
            mdr_in_q     <= 1'b0;
            mdr_out_q    <= 1'b0;
            ir_in_q      <= 1'b0;
            y_in_q       <= 1'b0;
            z_in_q       <= 1'b0;
            z_low_out_q  <= 1'b0;
            z_high_out_q <= 1'b0;
            hi_in_q      <= 1'b0;
            lo_in_q      <= 1'b0;
            alu_op_q     <= '0;
            op_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            rc_q         <= '0;
`ifdef ALU_SEQ_PRELOAD_EN
            pre_idx_q    <= '0;
`endif
        end else begin
            // Strobes are single-step pulses; each state below re-asserts only its own.
            done_q       <= 1'b0;
            r_in_q       <= '0;
            r_out_q      <= '0;
            pc_out_q     <= 1'b0;
            mar_in_q     <= 1'b0;
            inc_pc_q     <= 1'b0;
            read_q       <= 1'b0;
            mdr_in_q     <= 1'b0;
            mdr_out_q    <= 1'b0;
            ir_in_q      <= 1'b0;
            y_in_q       <= 1'b0;
            z_in_q       <= 1'b0;
            z_low_out_q  <= 1'b0;
            z_high_out_q <= 1'b0;
            hi_in_q      <= 1'b0;
            lo_in_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= opcode_in;
                        ra_q     <= ra;
                        rb_q     <= rb;
                        rc_q     <= rc;
                        alu_op_q <= opcode_in;
                        ready_q  <= 1'b0;
                        state_q  <= S_T0;
                        pc_out_q <= 1'b1;
                        mar_in_q <= 1'b1;
                        inc_pc_q <= 1'b1;
                    end
`ifdef ALU_SEQ_PRELOAD_EN
                    else if (pre_valid) begin
                        pre_idx_q <= pre_idx;
                        ready_q   <= 1'b0;
                        state_q   <= S_PRE_A;
                        read_q    <= 1'b1;
                        mdr_in_q  <= 1'b1;
                    end
`endif
                end
                S_T0: begin
                    state_q  <= S_T1;
                    read_q   <= 1'b1;
                    mdr_in_q <= 1'b1;
                end
                S_T1: begin
                    state_q   <= S_T2;
                    mdr_out_q <= 1'b1;
                    ir_in_q   <= 1'b1;
                end
                S_T2: begin
                    state_q <= S_T3;
                    r_out_q <= reg_sel(rb_q);
                    y_in_q  <= 1'b1;
                end
                S_T3: begin
                    state_q <= S_T4;
                    r_out_q <= reg_sel(rc_q);
                    z_in_q  <= 1'b1;
                end
                S_T4: begin
                    state_q     <= S_T5;
                    z_low_out_q <= 1'b1;
                    if (is_muldiv(op_q)) begin
                        lo_in_q <= 1'b1;
                    end else begin
                        r_in_q <= reg_sel(ra_q);
                        done_q <= 1'b1;
                    end
                end
                S_T5: begin
                    if (is_muldiv(op_q)) begin
                        state_q      <= S_T6;
                        z_high_out_q <= 1'b1;
                        hi_in_q      <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b1;
                        alu_op_q <= '0;
                    end
                end
                S_T6: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b1;
                    alu_op_q <= '0;
                end
`ifdef ALU_SEQ_PRELOAD_EN
                S_PRE_A: begin
                    state_q   <= S_PRE_B;
                    mdr_out_q <= 1'b1;
                    r_in_q    <= reg_sel(pre_idx_q);
                    done_q    <= 1'b1;
                end
                S_PRE_B: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
`endif
                default: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b1;
                    alu_op_q <= '0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign ready      = ready_q;
    assign done       = done_q;
    assign r_in       = r_in_q;
    assign r_out      = r_out_q;
    assign pc_out     = pc_out_q;
    assign mar_in     = mar_in_q;
    assign inc_pc     = inc_pc_q;
    assign read       = read_q;
    assign mdr_in     = mdr_in_q;
    assign mdr_out    = mdr_out_q;
    assign ir_in      = ir_in_q;
    assign y_in       = y_in_q;
    assign z_in       = z_in_q;
    assign z_low_out  = z_low_out_q;
    assign z_high_out = z_high_out_q;
    assign hi_in      = hi_in_q;
    assign lo_in      = lo_in_q;
    assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: two instances (16 and 8 registers) share stimulus;
// a transaction-level model predicts every output each cycle, and directed
// literal checks pin the model at the points the test plan names.
module tb_alu_rr_sequencer;

    localparam logic [4:0] MULOP = 5'b01111;
    localparam logic [4:0] DIVOP = 5'b10000;

    // strobe vector bit order: pc_out..lo_in
    localparam logic [12:0] PC_OUT = 13'h1000, MAR_IN = 13'h0800, INC_PC = 13'h0400,
                            READ = 13'h0200, MDR_IN = 13'h0100, MDR_OUT = 13'h0080,
                            IR_IN = 13'h0040, Y_IN = 13'h0020, Z_IN = 13'h0010,
                            Z_LOW = 13'h0008, Z_HIGH = 13'h0004, HI_IN = 13'h0002,
                            LO_IN = 13'h0001;

    typedef logic [55:0] ovec_t;

    logic clk = 1'b0;
    logic clear, start;
    logic [4:0] opcode_in;
    logic [3:0] ra, rb, rc;
`ifdef ALU_SEQ_PRELOAD_EN
    logic pre_valid;
    logic [3:0] pre_idx;
`endif

    logic a_ready, a_done, a_pc_out, a_mar_in, a_inc_pc, a_read, a_mdr_in, a_mdr_out, a_ir_in;
    logic a_y_in, a_z_in, a_z_low_out, a_z_high_out, a_hi_in, a_lo_in;
    logic [3:0] a_state;
    logic [15:0] a_r_in, a_r_out;
    logic [4:0] a_alu_op;
    logic b_ready, b_done, b_pc_out, b_mar_in, b_inc_pc, b_read, b_mdr_in, b_mdr_out, b_ir_in;
    logic b_y_in, b_z_in, b_z_low_out, b_z_high_out, b_hi_in, b_lo_in;
    logic [3:0] b_state;
    logic [7:0] b_r_in, b_r_out;
    logic [4:0] b_alu_op;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.NUM_REGS(16), .IDX_W(4)) u_dut16 (
        .clock(clk), .clear(clear), .start(start), .opcode_in(opcode_in),
        .ra(ra), .rb(rb), .rc(rc),
`ifdef ALU_SEQ_PRELOAD_EN
        .pre_valid(pre_valid), .pre_idx(pre_idx),
`endif
        .ready(a_ready), .done(a_done), .state(a_state), .r_in(a_r_in), .r_out(a_r_out),
        .pc_out(a_pc_out), .mar_in(a_mar_in), .inc_pc(a_inc_pc), .read(a_read),
        .mdr_in(a_mdr_in), .mdr_out(a_mdr_out), .ir_in(a_ir_in), .y_in(a_y_in),
        .z_in(a_z_in), .z_low_out(a_z_low_out), .z_high_out(a_z_high_out),
        .hi_in(a_hi_in), .lo_in(a_lo_in), .alu_op(a_alu_op)
    );

    alu_rr_sequencer #(.NUM_REGS(8), .IDX_W(4)) u_dut8 (
        .clock(clk), .clear(clear), .start(start), .opcode_in(opcode_in),
        .ra(ra), .rb(rb), .rc(rc),
`ifdef ALU_SEQ_PRELOAD_EN
        .pre_valid(pre_valid), .pre_idx(pre_idx),
`endif
        .ready(b_ready), .done(b_done), .state(b_state), .r_in(b_r_in), .r_out(b_r_out),
        .pc_out(b_pc_out), .mar_in(b_mar_in), .inc_pc(b_inc_pc), .read(b_read),
        .mdr_in(b_mdr_in), .mdr_out(b_mdr_out), .ir_in(b_ir_in), .y_in(b_y_in),
        .z_in(b_z_in), .z_low_out(b_z_low_out), .z_high_out(b_z_high_out),
        .hi_in(b_hi_in), .lo_in(b_lo_in), .alu_op(b_alu_op)
    );

    // ---------------- transaction-level reference model ----------------
    // kind: 0 idle, 1 normal op, 2 mul/div, 3 preload; step counts cycles since acceptance
    int         m_kind = 0;
    int         m_step = 0;
    logic [4:0] m_op;
    logic [3:0] m_ra, m_rb, m_rc, m_pidx;

    function automatic int last_step(input int kind);
        if (kind == 1) return 6;
        if (kind == 2) return 7;
        return 2;
    endfunction

    always @(posedge clk) begin
        if (clear) begin
            m_kind <= 0; m_step <= 0; m_op <= '0;
            m_ra <= '0; m_rb <= '0; m_rc <= '0; m_pidx <= '0;
        end else if (m_kind != 0) begin
            if (m_step == last_step(m_kind)) begin
                m_kind <= 0; m_step <= 0;
            end else begin
                m_step <= m_step + 1;
            end
        end else if (start) begin
            m_kind <= (opcode_in == MULOP || opcode_in == DIVOP) ? 2 : 1;
            m_step <= 1;
            m_op <= opcode_in; m_ra <= ra; m_rb <= rb; m_rc <= rc;
        end
`ifdef ALU_SEQ_PRELOAD_EN
        else if (pre_valid) begin
            m_kind <= 3; m_step <= 1; m_pidx <= pre_idx;
        end
`endif
    end

    function automatic logic [15:0] onehot(input logic [3:0] idx, input int nregs);
        if (int'(idx) < nregs) return 16'(1) << idx;
        return 16'h0000;
    endfunction

    function automatic ovec_t pack(input logic rdy, input logic dn, input logic [3:0] st,
                                   input logic [15:0] ri, input logic [15:0] ro,
                                   input logic [12:0] s, input logic [4:0] op);
        return {rdy, dn, st, ri, ro, s, op};
    endfunction

    function automatic ovec_t model_vec(input int nregs);
        logic rdy, dn;
        logic [3:0] st;
        logic [15:0] ri, ro;
        logic [12:0] s;
        logic [4:0] op;
        rdy = 1'b0; dn = 1'b0; st = 4'd0; ri = '0; ro = '0; s = '0; op = '0;
        if (m_kind == 0) begin
            rdy = 1'b1;
        end else if (m_kind == 3) begin
            st = 4'(7 + m_step);
            if (m_step == 1) s = READ | MDR_IN;
            else begin s = MDR_OUT; ri = onehot(m_pidx, nregs); dn = 1'b1; end
        end else begin
            st = 4'(m_step);
            op = m_op;
            case (m_step)
                1: s = PC_OUT | MAR_IN | INC_PC;
                2: s = READ | MDR_IN;
                3: s = MDR_OUT | IR_IN;
                4: begin s = Y_IN; ro = onehot(m_rb, nregs); end
                5: begin s = Z_IN; ro = onehot(m_rc, nregs); end
                6: begin
                    if (m_kind == 2) s = Z_LOW | LO_IN;
                    else begin s = Z_LOW; ri = onehot(m_ra, nregs); dn = 1'b1; end
                end
                default: begin s = Z_HIGH | HI_IN; dn = 1'b1; end
            endcase
        end
        return pack(rdy, dn, st, ri, ro, s, op);
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            ovec_t act_a, act_b, exp_a, exp_b;
            act_a = pack(a_ready, a_done, a_state, a_r_in, a_r_out,
                         {a_pc_out, a_mar_in, a_inc_pc, a_read, a_mdr_in, a_mdr_out, a_ir_in,
                          a_y_in, a_z_in, a_z_low_out, a_z_high_out, a_hi_in, a_lo_in}, a_alu_op);
            act_b = pack(b_ready, b_done, b_state, {8'h00, b_r_in}, {8'h00, b_r_out},
                         {b_pc_out, b_mar_in, b_inc_pc, b_read, b_mdr_in, b_mdr_out, b_ir_in,
                          b_y_in, b_z_in, b_z_low_out, b_z_high_out, b_hi_in, b_lo_in}, b_alu_op);
            exp_a = model_vec(16);
            exp_b = model_vec(8);
            n_total++;
            if (act_a !== exp_a)
                $display("FAIL model16 t=%0t: got %h expected %h", $time, act_a, exp_a);
            else n_pass++;
            n_total++;
            if (act_b !== exp_b)
                $display("FAIL model8 t=%0t: got %h expected %h", $time, act_b, exp_b);
            else n_pass++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
        start = 1'b1; opcode_in = op; ra = a; rb = b; rc = c;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; opcode_in = '0; ra = '0; rb = '0; rc = '0;
`ifdef ALU_SEQ_PRELOAD_EN
        pre_valid = 1'b0; pre_idx = '0;
`endif
        step();
        cmp_en = 1'b1;
        step();
        clear = 1'b0;
        chk("reset_state", 32'(a_state), 32'd0);
        chk("reset_ready", 32'(a_ready), 32'd1);
        chk("reset_strobes", {a_r_in, a_r_out}, 32'd0);
        chk("reset_alu_op", 32'(a_alu_op), 32'd0);
        step();

        // normal op: 00100, ra=7 rb=4 rc=3
        issue(5'b00100, 4'd7, 4'd4, 4'd3);
        chk("norm_t0_state", 32'(a_state), 32'd1);
        step(); step(); step();
        chk("norm_t3_r_out", 32'(a_r_out), 32'h0010);
        chk("norm_t3_y_in", 32'(a_y_in), 32'd1);
        step();
        chk("norm_t4_r_out", 32'(a_r_out), 32'h0008);
        chk("norm_t4_z_in", 32'(a_z_in), 32'd1);
        chk("norm_t4_alu_op", 32'(a_alu_op), 32'h04);
        step();
        chk("norm_t5_r_in", 32'(a_r_in), 32'h0080);
        chk("norm_t5_zlow_done", {a_z_low_out, a_done}, 32'd3);
        step();
        chk("norm_ready_after", {a_ready, a_done}, 32'd2);

        // back-to-back MUL accepted in the ready cycle: ra=2 rb=5 rc=6
        issue(MULOP, 4'd2, 4'd5, 4'd6);
        chk("mul_t0_state", 32'(a_state), 32'd1);
        step(); step(); step(); step(); step();
        chk("mul_t5_lo_zlow", {a_lo_in, a_z_low_out, a_done}, 32'd6);
        chk("mul_t5_r_in", 32'(a_r_in), 32'd0);
        step();
        chk("mul_t6_hi_zhigh_done", {a_hi_in, a_z_high_out, a_done}, 32'd7);
        chk("mul_t6_state", 32'(a_state), 32'd7);
        step();
        chk("mul_ready_after", 32'(a_ready), 32'd1);

        // clear during T3
        issue(5'b00001, 4'd7, 4'd4, 4'd3);
        step(); step(); step();
        chk("clr_in_t3", 32'(a_state), 32'd4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_state", 32'(a_state), 32'd0);
        chk("clr_ready", {a_ready, a_done, a_y_in, a_z_in}, 32'd8);
        chk("clr_r_out", 32'(a_r_out), 32'd0);
        chk("clr_alu_op", 32'(a_alu_op), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("clr_no_r_in", 32'(a_r_in), 32'd0);
        end

        // start while busy is ignored: ra=9, then start with ra=1 during T2
        issue(5'b00011, 4'd9, 4'd1, 4'd2);
        step(); step();
        chk("busy_in_t2", 32'(a_state), 32'd3);
        start = 1'b1; ra = 4'd1;
        step();
        start = 1'b0;
        step(); step();
        chk("busy_t5_r_in", 32'(a_r_in), 32'h0200);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("busy_no_second", {28'd0, a_state}, 32'd0);
        end

        // out-of-range index on the 8-register instance: ra=3 rb=12 rc=5
        issue(5'b00001, 4'd3, 4'd12, 4'd5);
        step(); step(); step();
        chk("oor8_t3_r_out", 32'(b_r_out), 32'd0);
        chk("oor8_t3_y_in", 32'(b_y_in), 32'd1);
        chk("oor16_t3_r_out", 32'(a_r_out), 32'h1000);
        step();
        chk("oor8_t4_r_out", 32'(b_r_out), 32'h20);
        step();
        chk("oor8_t5_r_in_done", {b_r_in, b_done}, 32'h11);
        step();
        chk("oor8_ready", 32'(b_ready), 32'd1);

`ifdef ALU_SEQ_PRELOAD_EN
        pre_valid = 1'b1; pre_idx = 4'd4;
        step();
        pre_valid = 1'b0;
        chk("pre_a_state", 32'(a_state), 32'd8);
        chk("pre_a_strobes", {a_read, a_mdr_in}, 32'd3);
        step();
        chk("pre_b_state", 32'(a_state), 32'd9);
        chk("pre_b_r_in", 32'(a_r_in), 32'h0010);
        chk("pre_b_mdr_done", {a_mdr_out, a_done}, 32'd3);
        step();
        chk("pre_ready", 32'(a_ready), 32'd1);
        pre_valid = 1'b1;
        issue(5'b00010, 4'd1, 4'd2, 4'd3);
        pre_valid = 1'b0;
        chk("pre_start_priority", 32'(a_state), 32'd1);
        for (int i = 0; i < 6; i++) step();
`endif

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
